// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/timing generator with pixel-rate tick and visible-area coordinates
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISP);
    localparam logic [9:0] V_VIS  = 10'(V_DISP);
    localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_pos_q, h_pos_d;
    logic [9:0]       v_pos_q, v_pos_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             valid_q, valid_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic             tick;
    logic             visible;

    assign tick     = (div_cnt_q == DIV_MAX);
    // Gated so a single-clock divider still reports no tick while in reset.
    assign pix_tick = tick & ~rst;

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        h_pos_d   = h_pos_q;
        v_pos_d   = v_pos_q;
        if (tick) begin
            if (h_pos_q == H_LAST) begin
                h_pos_d = '0;
                v_pos_d = (v_pos_q == V_LAST) ? 10'd0 : v_pos_q + 10'd1;
            end else begin
                h_pos_d = h_pos_q + 10'd1;
            end
        end
    end

    // Outputs decode the current position and land one clk later.
    always_comb begin
        visible       = (h_pos_q < H_VIS) && (v_pos_q < V_VIS);
        valid_d       = visible;
        h_cnt_d       = visible ? h_pos_q : 10'd0;
        v_cnt_d       = visible ? v_pos_q : 10'd0;
        hsync_d       = !((h_pos_q >= HS_BEG) && (h_pos_q <= HS_END));
        vsync_d       = !((v_pos_q >= VS_BEG) && (v_pos_q <= VS_END));
        frame_start_d = tick && (h_pos_q == 10'd0) && (v_pos_q == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_pos_q       <= '0;
            v_pos_q       <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            valid_q       <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            valid_q       <= valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default and reduced timing)
module tb_vga_timing_gen;

    typedef struct {
        int         k;
        logic       pt, val, hs, vs, fs;
        logic [9:0] hc, vc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    logic       pt_a, val_a, hs_a, vs_a, fs_a;
    logic [9:0] hc_a, vc_a;
    logic       pt_b, val_b, hs_b, vs_b, fs_b;
    logic [9:0] hc_b, vc_b;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_tick(pt_a), .h_cnt(hc_a), .v_cnt(vc_a),
        .valid(val_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    // Reduced frame: 2 clk/pixel, 15 pixels/line (hsync 10..12), 8 lines (vsync 5..6).
    vga_timing_gen #(
        .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_tick(pt_b), .h_cnt(hc_b), .v_cnt(vc_b),
        .valid(val_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   kcnt_a = 0;
    int   kcnt_b = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // k = number of clk edges that sampled reset low since the last reset.
    always @(posedge clk) kcnt_a <= rst_a ? 0 : kcnt_a + 1;
    always @(posedge clk) kcnt_b <= rst_b ? 0 : kcnt_b + 1;

    function automatic void pa(int k, bit pt, bit val, bit hs, bit vs, bit fs, int hc, int vc);
        exp_t e;
        e.k = k; e.pt = pt; e.val = val; e.hs = hs; e.vs = vs; e.fs = fs;
        e.hc = 10'(hc); e.vc = 10'(vc);
        q_a.push_back(e);
    endfunction

    function automatic void pb(int k, bit pt, bit val, bit hs, bit vs, bit fs, int hc, int vc);
        exp_t e;
        e.k = k; e.pt = pt; e.val = val; e.hs = hs; e.vs = vs; e.fs = fs;
        e.hc = 10'(hc); e.vc = 10'(vc);
        q_b.push_back(e);
    endfunction

    function automatic void chk(string tag, string fld, int k, logic [9:0] act, logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s k=%0d actual=%0d required=%0d", tag, fld, k, act, exp);
        end
    endfunction

    function automatic void cmp_all(string tag, exp_t e, logic pt, logic val, logic hs, logic vs,
                                    logic fs, logic [9:0] hc, logic [9:0] vc);
        chk(tag, "pix_tick",    e.k, {9'd0, pt},  {9'd0, e.pt});
        chk(tag, "valid",       e.k, {9'd0, val}, {9'd0, e.val});
        chk(tag, "hsync",       e.k, {9'd0, hs},  {9'd0, e.hs});
        chk(tag, "vsync",       e.k, {9'd0, vs},  {9'd0, e.vs});
        chk(tag, "frame_start", e.k, {9'd0, fs},  {9'd0, e.fs});
        chk(tag, "h_cnt",       e.k, hc, e.hc);
        chk(tag, "v_cnt",       e.k, vc, e.vc);
    endfunction

    always @(negedge clk) begin
        if (q_a.size() > 0 && q_a[0].k == kcnt_a && (kcnt_a != 0 || rst_a)) begin
            ea = q_a.pop_front();
            cmp_all("dflt", ea, pt_a, val_a, hs_a, vs_a, fs_a, hc_a, vc_a);
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0 && q_b[0].k == kcnt_b && (kcnt_b != 0 || rst_b)) begin
            eb = q_b.pop_front();
            cmp_all("small", eb, pt_b, val_b, hs_b, vs_b, fs_b, hc_b, vc_b);
        end
    end

    initial begin
        int tmo;
        //   k     pt val hs vs fs  hc   vc
        pa(0,    0, 0, 1, 1, 0,   0,  0);
        pa(1,    0, 1, 1, 1, 0,   0,  0);
        pa(3,    1, 1, 1, 1, 0,   0,  0);
        pa(4,    0, 1, 1, 1, 1,   0,  0);
        pa(5,    0, 1, 1, 1, 0,   1,  0);
        pa(7,    1, 1, 1, 1, 0,   1,  0);
        pa(9,    0, 1, 1, 1, 0,   2,  0);
        pa(2560, 0, 1, 1, 1, 0, 639,  0);
        pa(2561, 0, 0, 1, 1, 0,   0,  0);
        pa(2624, 0, 0, 1, 1, 0,   0,  0);
        pa(2625, 0, 0, 0, 1, 0,   0,  0);
        pa(3008, 0, 0, 0, 1, 0,   0,  0);
        pa(3009, 0, 0, 1, 1, 0,   0,  0);
        pa(3200, 0, 0, 1, 1, 0,   0,  0);
        pa(3201, 0, 1, 1, 1, 0,   0,  1);
        pa(3203, 1, 1, 1, 1, 0,   0,  1);
        pa(3205, 0, 1, 1, 1, 0,   1,  1);
        pa(6401, 0, 1, 1, 1, 0,   0,  2);

        pb(0,    0, 0, 1, 1, 0,   0,  0);
        pb(1,    1, 1, 1, 1, 0,   0,  0);
        pb(2,    0, 1, 1, 1, 1,   0,  0);
        pb(3,    1, 1, 1, 1, 0,   1,  0);
        pb(20,   0, 0, 1, 1, 0,   0,  0);
        pb(21,   1, 0, 0, 1, 0,   0,  0);
        pb(26,   0, 0, 0, 1, 0,   0,  0);
        pb(27,   1, 0, 1, 1, 0,   0,  0);
        pb(105,  1, 1, 1, 1, 0,   7,  3);
        pb(107,  1, 0, 1, 1, 0,   0,  0);
        pb(121,  1, 0, 1, 1, 0,   0,  0);
        pb(150,  0, 0, 1, 1, 0,   0,  0);
        pb(151,  1, 0, 1, 0, 0,   0,  0);
        pb(210,  0, 0, 1, 0, 0,   0,  0);
        pb(211,  1, 0, 1, 1, 0,   0,  0);
        pb(240,  0, 0, 1, 1, 0,   0,  0);
        pb(241,  1, 1, 1, 1, 0,   0,  0);
        pb(242,  0, 1, 1, 1, 1,   0,  0);
        pb(243,  1, 1, 1, 1, 0,   1,  0);
        pb(323,  1, 0, 0, 1, 0,   0,  0);

        repeat (3) @(negedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Mid-hsync reset of the reduced instance (pixel h=11, v=2 of its second frame).
        tmo = 0;
        while (kcnt_b != 323 && tmo < 2000) begin
            @(negedge clk);
            tmo++;
        end
        n_cmp++;
        if (kcnt_b != 323) begin
            n_bad++;
            $display("FAIL small.reach_k323 actual=%0d required=323", kcnt_b);
        end
        pb(0,    0, 0, 1, 1, 0,   0,  0);
        pb(1,    1, 1, 1, 1, 0,   0,  0);
        pb(2,    0, 1, 1, 1, 1,   0,  0);
        pb(241,  1, 1, 1, 1, 0,   0,  0);
        pb(242,  0, 1, 1, 1, 1,   0,  0);
        pb(243,  1, 1, 1, 1, 0,   1,  0);
        #1 rst_b = 1'b1;
        @(negedge clk);
        #1 rst_b = 1'b0;

        tmo = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && tmo < 12000) begin
            @(negedge clk);
            tmo++;
        end
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d/%0d pending required=0/0", q_a.size(), q_b.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
